cmp_sweep_driver: RTL

CMP_SWEEP_DRIVER -- requirements
Module: cmp_sweep_driver

---
 rtl/cmp_sweep_if.sv | 24 ++
 rtl/cmp_sweep_driver.sv | 111 +++++++++++
 2 files changed

// File: rtl/cmp_sweep_if.sv
// Bundle between the sweep driver, its requester and the comparator under test.
// slave = the sweep driver, master = the requester/comparator side.
interface cmp_sweep_if;
    logic       start;
    logic       abort;
    logic [3:0] A;
    logic [3:0] B;
    logic       sel;
    logic       y_in;
    logic       busy;
    logic       done;
    logic [9:0] err_count;
    logic [8:0] fail_vec;

    modport slave (
        input  start, abort, y_in,
        output A, B, sel, busy, done, err_count, fail_vec
    );

    modport master (
        output start, abort, y_in,
        input  A, B, sel, busy, done, err_count, fail_vec
    );
endinterface

// File: rtl/cmp_sweep_driver.sv
// Exhaustive 512-vector sweep of a 4-bit eq/neq comparator, counting mismatches.
// Optional first-failing-vector capture under macro CMP_SWEEP_FIRST_FAIL_EN.
module cmp_sweep_driver #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    cmp_sweep_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_e;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_e     state_q;
    logic [8:0] idx_q;
    logic [3:0] cnt_q;
    logic [3:0] a_q, b_q;
    logic       sel_q, busy_q, done_q;
    logic [9:0] err_q;

    logic       exp_y, mismatch, idle_start;
    logic [8:0] idx_d;
    logic [9:0] err_d;

    assign exp_y      = sel_q ? (a_q == b_q) : (a_q != b_q);
    // abort wins over the sample taken in the same cycle
    assign mismatch   = (state_q == SAMPLE) && !bus.abort && (bus.y_in != exp_y);
    assign idle_start = ((state_q == IDLE) || (state_q == DONE)) && bus.start;
    assign idx_d      = idx_q + 9'd1;
    assign err_d      = (err_q == 10'h3FF) ? err_q : err_q + 10'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sel_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state_q              <= DRIVE;
                        idx_q                <= '0;
                        cnt_q                <= '0;
                        err_q                <= '0;
                        {a_q, b_q, sel_q}    <= '0;
                        busy_q               <= 1'b1;
                        done_q               <= 1'b0;
                    end
                end
                DRIVE: begin
                    if (bus.abort) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else if (cnt_q == SETTLE_LAST) begin
                        state_q <= SAMPLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q   <= cnt_q + 4'd1;
                    end
                end
                SAMPLE: begin
                    if (bus.abort) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        if (mismatch) err_q <= err_d;
                        if (idx_q == 9'd511) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q           <= DRIVE;
                            idx_q             <= idx_d;
                            {a_q, b_q, sel_q} <= idx_d;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef CMP_SWEEP_FIRST_FAIL_EN
    logic [8:0] fail_q;

    // err_q is zero only until the first mismatch of the current sweep
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                       fail_q <= '0;
        else if (idle_start)              fail_q <= '0;
        else if (mismatch && err_q == '0) fail_q <= {a_q, b_q, sel_q};
    end

    assign bus.fail_vec = fail_q;
`else
    assign bus.fail_vec = '0;
`endif

    assign bus.A         = a_q;
    assign bus.B         = b_q;
    assign bus.sel       = sel_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err_count = err_q;
endmodule
